// File: rtl/ntt_output_reorder_pkg.sv
// Shared types and helpers for the NTT output reorder stage.
// Holds FSM encodings and the bit-reverse index function.
package ntt_output_reorder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Reverse the low logn bits of x; upper bits come back zero.
   function automatic logic [15:0] bitrev(
      input logic [15:0] x,
      input int          logn
   );
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < logn) r[i] = x[logn-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_reorder_ram.sv
// N x LOGQ simple dual-port RAM with registered read.
// One write port, one read port, 1-cycle read latency.
module ntt_reorder_ram #(
   parameter int LOGQ = 64,
   parameter int LOGN = 10
) (
   input  logic            clk,
   input  logic            we,
   input  logic [LOGN-1:0] waddr,
   input  logic [LOGQ-1:0] wdata,
   input  logic            re,
   input  logic [LOGN-1:0] raddr,
   output logic [LOGQ-1:0] rdata
);

   logic [LOGQ-1:0] mem [2**LOGN];

   // write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ntt_output_reorder.sv
// Captures one NTT polynomial, then streams it out valid/ready.
// Define NTT_REORDER_BITREV_EN for bit-reversed readout order.
module ntt_output_reorder
   import ntt_output_reorder_pkg::*;
#(
   parameter int LOGQ = 64,
   parameter int LOGN = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            wea,
   input  logic [LOGN-1:0] waddr,
   input  logic [LOGQ-1:0] data_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGQ-1:0] out_data,
   output logic            out_last,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int N = 2**LOGN;
   localparam logic [LOGN:0] CNT_N = N[LOGN:0];
   localparam logic [LOGN:0] CNT_LAST = CNT_N - 1'b1;

   state_t state;
   state_t state_nx;

   logic [LOGN:0]   fill_cnt;
   logic [LOGN:0]   rd_cnt;
   logic            fill_we;
   logic            start_ok;
   logic            pop;
   logic            issue;
   logic [1:0]      occ;
   logic [LOGN-1:0] raddr;
   logic [LOGQ-1:0] rdata;
   logic            rd_pend;
   logic            rd_last;
   logic            skid_valid;
   logic [LOGQ-1:0] skid_data;
   logic            skid_last;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = FILL;
         FILL:    if (wea && fill_cnt == CNT_LAST)
                     state_nx = DRAIN;
         DRAIN:   if (pop && out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state-decoded controls
   always_comb begin
      busy     = 1'b0;
      fill_we  = 1'b0;
      start_ok = 1'b0;
      unique case (state)
         IDLE:  start_ok = start;
         FILL:  begin
            busy    = 1'b1;
            fill_we = wea;
         end
         DRAIN: busy = 1'b1;
         default: ;
      endcase
   end

   // issue a read only if the skid can absorb it;
   // in-flight read counts as an occupied slot
   always_comb begin
      pop   = out_valid && out_ready;
      occ   = 2'(out_valid) + 2'(skid_valid)
            + 2'(rd_pend) - 2'(pop);
      issue = (state == DRAIN) && (rd_cnt != CNT_N)
            && (occ < 2'd2);
   end

`ifdef NTT_REORDER_BITREV_EN
   logic [15:0] rev;
   // bit-reversed read order
   always_comb begin
      rev   = bitrev(16'(rd_cnt[LOGN-1:0]), LOGN);
      raddr = rev[LOGN-1:0];
   end
`else
   // natural read order
   always_comb begin
      raddr = rd_cnt[LOGN-1:0];
   end
`endif

   // fill/read counters
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt <= '0;
         rd_cnt   <= '0;
      end else if (start_ok) begin
         fill_cnt <= '0;
         rd_cnt   <= '0;
      end else begin
         if (fill_we) fill_cnt <= fill_cnt + 1'b1;
         if (issue)   rd_cnt   <= rd_cnt + 1'b1;
      end
   end

   // sticky error for writes outside FILL
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (wea && state != FILL)
         err <= 1'b1;
      else if (start_ok)
         err <= 1'b0;
   end

   ntt_reorder_ram #(
      .LOGQ (LOGQ),
      .LOGN (LOGN)
   ) u_ram (
      .clk   (clk),
      .we    (fill_we),
      .waddr (waddr),
      .wdata (data_in),
      .re    (issue),
      .raddr (raddr),
      .rdata (rdata)
   );

   // read pipeline, output register and skid slot
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend    <= 1'b0;
         rd_last    <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         done       <= 1'b0;
      end else begin
         rd_pend <= issue;
         rd_last <= (rd_cnt == CNT_LAST);
         done    <= pop && out_last;
         if (!out_valid || out_ready) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_data   <= skid_data;
               out_last   <= skid_last;
               skid_valid <= rd_pend;
               skid_data  <= rdata;
               skid_last  <= rd_last;
            end else begin
               out_valid <= rd_pend;
               out_last  <= rd_pend && rd_last;
               if (rd_pend) out_data <= rdata;
            end
         end else if (rd_pend) begin
            skid_valid <= 1'b1;
            skid_data  <= rdata;
            skid_last  <= rd_last;
         end
      end
   end

endmodule

// File: tb/tb_ntt_output_reorder.sv
// Directed bench for ntt_output_reorder at LOGN=3.
// Coefficients are 3*waddr; expected order hand-tabulated.
module tb_ntt_output_reorder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        wea;
   logic [2:0]  waddr;
   logic [63:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q [8];
   int nat_ord [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
   int scr_ord [8] = '{7, 0, 5, 2, 3, 6, 1, 4};
   int rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   ntt_output_reorder #(
      .LOGQ (64),
      .LOGN (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .wea       (wea),
      .waddr     (waddr),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int ord [8], input bit start_drain);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wea     = 1'b1;
         waddr   = 3'(ord[i]);
         data_in = 64'(3 * ord[i]);
         step();
      end
      wea = 1'b0;
      if (start_drain) start = 1'b1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL lat_T valid=%b busy=%b want 0 1",
                  out_valid, busy);
      end
      step();
      start = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL lat_T1 valid=%b want 0", out_valid);
      end
      step();
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL lat_T2 valid=%b want 1", out_valid);
      end
   endtask

   // mode 0: ready always high; mode 1: ready 1,0,0,1
   task automatic collect(input int mode, output int cycles);
      int          k = 0;
      int          cyc = 0;
      logic        hv = 1'b0;
      logic [63:0] hd = '0;
      logic        hl = 1'b0;
      while (k < 8 && cyc < 200) begin
         out_ready = (mode == 0) ? 1'b1
                   : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (hv) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== hd
                || out_last !== hl) begin
               bad++;
               $display("FAIL hold v=%b d=%0d l=%b want 1 %0d %b",
                        out_valid, out_data, out_last, hd, hl);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (out_data !== exp_q[k]
                || out_last !== (k == 7)) begin
               bad++;
               $display("FAIL elem%0d d=%0d l=%b want %0d %b",
                        k, out_data, out_last, exp_q[k], k == 7);
            end
            k++;
         end
         hv = out_valid && !out_ready;
         hd = out_data;
         hl = out_last;
         step();
         cyc++;
      end
      out_ready = 1'b1;
      total++;
      if (k != 8) begin
         bad++;
         $display("FAIL handshakes got=%0d want 8", k);
      end
      cycles = cyc;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL end done=%b busy=%b valid=%b want 1 0 0",
                  done, busy, out_valid);
      end
      step();
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL done_pulse done=%b valid=%b want 0 0",
                  done, out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++;
      if (out_valid !== 0 || out_data !== 0 || out_last !== 0
          || busy !== 0 || done !== 0 || err !== 0) begin
         bad++;
         $display("FAIL reset v=%b d=%0d l=%b b=%b dn=%b e=%b want 0",
                  out_valid, out_data, out_last, busy, done, err);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_stream();
      int cyc;
      fill(nat_ord, 1'b0);
      collect(0, cyc);
      total++;
      if (cyc != 8) begin
         bad++;
         $display("FAIL stream_cycles got=%0d want 8", cyc);
      end
   endtask

   task automatic test_stall();
      int cyc;
      fill(nat_ord, 1'b0);
      collect(1, cyc);
   endtask

   task automatic test_err_start();
      int cyc;
      wea     = 1'b1;
      waddr   = 3'd5;
      data_in = 64'd999;
      step();
      wea = 1'b0;
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL err_set got=%b want 1", err);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL err_clr err=%b busy=%b want 0 1", err, busy);
      end
      for (int i = 0; i < 8; i++) begin
         wea     = 1'b1;
         waddr   = 3'(i);
         data_in = 64'(3 * i);
         step();
      end
      wea   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL drain_start valid=%b busy=%b want 1 1",
                  out_valid, busy);
      end
      collect(0, cyc);
   endtask

   task automatic test_reset_mid();
      int cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wea     = 1'b1;
         waddr   = 3'(i);
         data_in = 64'(100 + i);
         step();
      end
      wea = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy got=%b want 1", busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (out_valid !== 0 || out_data !== 0 || out_last !== 0
          || busy !== 0 || done !== 0 || err !== 0) begin
         bad++;
         $display("FAIL mid_rst v=%b d=%0d l=%b b=%b dn=%b e=%b want 0",
                  out_valid, out_data, out_last, busy, done, err);
      end
      step();
      fill(nat_ord, 1'b0);
      collect(0, cyc);
   endtask

   task automatic test_scrambled();
      int cyc;
      fill(scr_ord, 1'b0);
      collect(0, cyc);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      wea       = 1'b0;
      waddr     = '0;
      data_in   = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
`ifdef NTT_REORDER_BITREV_EN
         exp_q[i] = 64'(3 * rev_tab[i]);
`else
         exp_q[i] = 64'(3 * nat_ord[i]);
`endif
      end
      test_reset();
      test_stream();
      test_stall();
      test_err_start();
      test_reset_mid();
      test_scrambled();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
